// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded operands and control,
// resolves MEM/WB forwarding, detects load-use hazards and handles flush/hold.
//
// Handshake: there is no valid/ready pair here. id_stall is the "not ready" back to
// IF/ID; ex_hold is the downstream "not ready"; ex_valid marks a real instruction in EX.
module id_ex_operand_stage #(
  parameter int unsigned XLEN   = 32,
  parameter logic [4:0]  NOP_OP = 5'd0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_rd1,
  input  logic [XLEN-1:0] id_rd2,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_alusrc,
  input  logic [4:0]      id_alu_op,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            flush,
  input  logic            ex_hold,
  input  logic            mem_regwrite,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [4:0]      ex_alu_op,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_rd,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite
);

  logic [4:0]      ex_rs1_q;
  logic [4:0]      ex_rs2_q;
  logic [XLEN-1:0] ex_rs1_val_q;
  logic [XLEN-1:0] ex_rs2_val_q;
  logic [XLEN-1:0] ex_imm_q;
  logic            ex_alusrc_q;

  logic            wb_hit_id_rs1;
  logic            wb_hit_id_rs2;
  logic [XLEN-1:0] id_rs1_val;
  logic [XLEN-1:0] id_rs2_val;

  logic            mem_fwd_rs1;
  logic            mem_fwd_rs2;
  logic            wb_fwd_rs1;
  logic            wb_fwd_rs2;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  logic            hazard;

  // Register-file write-through: WB writes on the same edge ID reads.
  always_comb begin
    wb_hit_id_rs1 = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs1);
    wb_hit_id_rs2 = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs2);
    id_rs1_val    = wb_hit_id_rs1 ? wb_result : id_rd1;
    id_rs2_val    = wb_hit_id_rs2 ? wb_result : id_rd2;
  end

  // Forwarding onto the stored operands; MEM is younger so it wins over WB.
  always_comb begin
    mem_fwd_rs1 = mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rs1_q);
    mem_fwd_rs2 = mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rs2_q);
    wb_fwd_rs1  = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rs1_q);
    wb_fwd_rs2  = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rs2_q);

    if (mem_fwd_rs1)     fwd_rs1 = mem_result;
    else if (wb_fwd_rs1) fwd_rs1 = wb_result;
    else                 fwd_rs1 = ex_rs1_val_q;

    if (mem_fwd_rs2)     fwd_rs2 = mem_result;
    else if (wb_fwd_rs2) fwd_rs2 = wb_result;
    else                 fwd_rs2 = ex_rs2_val_q;
  end

  always_comb begin
    hazard = id_valid && ex_valid && ex_memread && (ex_rd != 5'd0) &&
             ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    id_stall = (hazard || ex_hold) && !flush;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_alu_op    <= NOP_OP;
      ex_rd        <= 5'd0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_memwrite  <= 1'b0;
      ex_rs1_q     <= 5'd0;
      ex_rs2_q     <= 5'd0;
      ex_rs1_val_q <= '0;
      ex_rs2_val_q <= '0;
      ex_imm_q     <= '0;
      ex_alusrc_q  <= 1'b0;
    end else if (flush || (hazard && !ex_hold)) begin
      // Bubble: only control is killed; data fields are don't-care.
      ex_valid    <= 1'b0;
      ex_alu_op   <= NOP_OP;
      ex_rd       <= 5'd0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
    end else if (ex_hold) begin
      // Refresh so a producer retiring out of WB during the hold is not lost.
      ex_rs1_val_q <= fwd_rs1;
      ex_rs2_val_q <= fwd_rs2;
    end else begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_alu_op    <= id_alu_op;
      ex_rd        <= id_rd;
      ex_regwrite  <= id_regwrite && id_valid;
      ex_memread   <= id_memread && id_valid;
      ex_memwrite  <= id_memwrite && id_valid;
      ex_rs1_q     <= id_rs1;
      ex_rs2_q     <= id_rs2;
      ex_rs1_val_q <= id_rs1_val;
      ex_rs2_val_q <= id_rs2_val;
      ex_imm_q     <= id_imm;
      ex_alusrc_q  <= id_alusrc;
    end
  end

  always_comb begin
    ex_a          = fwd_rs1;
    ex_store_data = fwd_rs2;
    ex_b          = ex_alusrc_q ? ex_imm_q : fwd_rs2;
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, forwarding priority, load-use,
// hold refresh, flush precedence and register-file write-through.
module tb_id_ex_operand_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rstn;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_rs1, id_rs2;
  logic            id_use_rs1, id_use_rs2;
  logic [4:0]      id_rd;
  logic [XLEN-1:0] id_rd1, id_rd2, id_imm;
  logic            id_alusrc;
  logic [4:0]      id_alu_op;
  logic            id_regwrite, id_memread, id_memwrite;
  logic            flush, ex_hold;
  logic            mem_regwrite;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_result;
  logic            wb_regwrite;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_result;
  logic            id_stall, ex_valid;
  logic [XLEN-1:0] ex_pc, ex_a, ex_b, ex_store_data;
  logic [4:0]      ex_alu_op, ex_rd;
  logic            ex_regwrite, ex_memread, ex_memwrite;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.XLEN(XLEN), .NOP_OP(5'd0)) dut (
    .clk(clk), .rstn(rstn),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_alusrc(id_alusrc),
    .id_alu_op(id_alu_op), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .flush(flush), .ex_hold(ex_hold),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_a(ex_a),
    .ex_b(ex_b), .ex_alu_op(ex_alu_op), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite)
  );

  task automatic clear_inputs();
    id_valid = 0; id_pc = '0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_rd1 = '0; id_rd2 = '0; id_imm = '0; id_alusrc = 0; id_alu_op = 0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0; flush = 0; ex_hold = 0;
    mem_regwrite = 0; mem_rd = 0; mem_result = '0;
    wb_regwrite = 0; wb_rd = 0; wb_result = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic [4:0] rd);
    clear_inputs();
    id_valid = 1; id_memread = 1; id_regwrite = 1; id_rd = rd; id_alu_op = 5'd1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 0;
    #12;
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", ex_valid); end
    checks++; if (ex_alu_op !== 5'd0) begin failures++; $display("FAIL reset_alu_op got=%0h exp=0", ex_alu_op); end
    checks++; if (ex_a !== 32'h0 || ex_b !== 32'h0) begin failures++; $display("FAIL reset_operands got a=%0h b=%0h exp=0", ex_a, ex_b); end
    checks++; if (ex_rd !== 5'd0 || ex_regwrite !== 1'b0 || ex_pc !== 32'h0) begin failures++; $display("FAIL reset_ctrl got rd=%0h rw=%0h pc=%0h exp=0", ex_rd, ex_regwrite, ex_pc); end
    rstn = 1;
    tick();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    id_valid = 1; id_pc = 32'h100; id_rs1 = 5'd1; id_use_rs1 = 1; id_rd1 = 32'd7;
    id_rd = 5'd5; id_alu_op = 5'd2; id_regwrite = 1;
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_a !== 32'd7 || ex_rd !== 5'd5) begin failures++; $display("FAIL mid_load got v=%0h a=%0h rd=%0h exp v=1 a=7 rd=5", ex_valid, ex_a, ex_rd); end
    checks++; if (ex_pc !== 32'h100 || ex_alu_op !== 5'd2) begin failures++; $display("FAIL mid_load_pc got pc=%0h op=%0h exp pc=100 op=2", ex_pc, ex_alu_op); end
    #2 rstn = 0;
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_alu_op !== 5'd0) begin failures++; $display("FAIL async_reset got v=%0h op=%0h exp v=0 op=0", ex_valid, ex_alu_op); end
    checks++; if (ex_a !== 32'h0 || ex_regwrite !== 1'b0 || ex_rd !== 5'd0) begin failures++; $display("FAIL async_reset_fields got a=%0h rw=%0h rd=%0h exp 0", ex_a, ex_regwrite, ex_rd); end
    #1 rstn = 1;
    clear_inputs();
    tick();
  endtask

  task automatic test_priority();
    clear_inputs();
    id_valid = 1; id_rs1 = 5'd3; id_use_rs1 = 1; id_rd1 = 32'd1; id_rd = 5'd10; id_regwrite = 1;
    tick();
    clear_inputs();
    mem_regwrite = 1; mem_rd = 5'd3; mem_result = 32'h20;
    wb_regwrite = 1; wb_rd = 5'd3; wb_result = 32'h10;
    #1;
    checks++; if (ex_a !== 32'h20) begin failures++; $display("FAIL fwd_mem_over_wb got=%0h exp=20", ex_a); end
    mem_regwrite = 0;
    #1;
    checks++; if (ex_a !== 32'h10) begin failures++; $display("FAIL fwd_wb got=%0h exp=10", ex_a); end
    mem_regwrite = 1; mem_rd = 5'd0; wb_rd = 5'd0;
    #1;
    checks++; if (ex_a !== 32'h1) begin failures++; $display("FAIL fwd_x0 got=%0h exp=1", ex_a); end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    drive_load(5'd4);
    clear_inputs();
    id_valid = 1; id_rs1 = 5'd4; id_use_rs1 = 1; id_rd = 5'd7; id_alu_op = 5'd3; id_regwrite = 1;
    #1;
    checks++; if (id_stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0h exp=1", id_stall); end
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_memread !== 1'b0) begin failures++; $display("FAIL lu_bubble got v=%0h rw=%0h mr=%0h exp 0", ex_valid, ex_regwrite, ex_memread); end
    checks++; if (id_stall !== 1'b0 || ex_alu_op !== 5'd0 || ex_rd !== 5'd0) begin failures++; $display("FAIL lu_one_cycle got st=%0h op=%0h rd=%0h exp 0", id_stall, ex_alu_op, ex_rd); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_alu_op !== 5'd3 || ex_regwrite !== 1'b1) begin failures++; $display("FAIL lu_capture got v=%0h rd=%0h op=%0h rw=%0h exp 1/7/3/1", ex_valid, ex_rd, ex_alu_op, ex_regwrite); end
    drive_load(5'd4);
    clear_inputs();
    id_valid = 1; id_rs2 = 5'd4; id_use_rs2 = 0; id_rd = 5'd8; id_alu_op = 5'd4; id_regwrite = 1;
    #1;
    checks++; if (id_stall !== 1'b0) begin failures++; $display("FAIL lu_unused_rs2 got=%0h exp=0", id_stall); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd8) begin failures++; $display("FAIL lu_nostall_capture got v=%0h rd=%0h exp 1/8", ex_valid, ex_rd); end
    clear_inputs();
    tick();
  endtask

  task automatic test_hold_refresh();
    clear_inputs();
    id_valid = 1; id_rs1 = 5'd6; id_use_rs1 = 1; id_rd1 = 32'h0; id_rd = 5'd11; id_regwrite = 1;
    tick();
    clear_inputs();
    id_valid = 1; id_rd = 5'd12; id_regwrite = 1;
    ex_hold = 1; wb_regwrite = 1; wb_rd = 5'd6; wb_result = 32'hAB;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ex_a !== 32'hAB || id_stall !== 1'b1) begin failures++; $display("FAIL hold_cycle%0d got a=%0h st=%0h exp a=ab st=1", i, ex_a, id_stall); end
      checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd11) begin failures++; $display("FAIL hold_keep%0d got v=%0h rd=%0h exp 1/11", i, ex_valid, ex_rd); end
      tick();
      wb_rd = 5'd8; wb_result = 32'h99;
    end
    ex_hold = 0; wb_regwrite = 0; id_valid = 0;
    #1;
    checks++; if (ex_a !== 32'hAB || id_stall !== 1'b0) begin failures++; $display("FAIL hold_release got a=%0h st=%0h exp a=ab st=0", ex_a, id_stall); end
    clear_inputs();
    tick();
  endtask

  task automatic test_flush();
    drive_load(5'd4);
    clear_inputs();
    id_valid = 1; id_rs1 = 5'd4; id_use_rs1 = 1; id_rd = 5'd9; id_regwrite = 1;
    ex_hold = 1; flush = 1;
    #1;
    checks++; if (id_stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%0h exp=0", id_stall); end
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_memread !== 1'b0 || ex_regwrite !== 1'b0 || ex_rd !== 5'd0 || ex_alu_op !== 5'd0) begin failures++; $display("FAIL flush_bubble got v=%0h mr=%0h rw=%0h rd=%0h op=%0h exp 0", ex_valid, ex_memread, ex_regwrite, ex_rd, ex_alu_op); end
    clear_inputs();
    tick();
  endtask

  task automatic test_write_through();
    clear_inputs();
    id_valid = 1; id_rs1 = 5'd9; id_rs2 = 5'd9; id_use_rs1 = 1; id_use_rs2 = 1;
    id_rd1 = 32'h0; id_rd2 = 32'h0; id_rd = 5'd13; id_memwrite = 1;
    wb_regwrite = 1; wb_rd = 5'd9; wb_result = 32'h55;
    tick();
    clear_inputs();
    #1;
    checks++; if (ex_a !== 32'h55) begin failures++; $display("FAIL wt_rs1 got=%0h exp=55", ex_a); end
    checks++; if (ex_b !== 32'h55 || ex_store_data !== 32'h55) begin failures++; $display("FAIL wt_rs2 got b=%0h sd=%0h exp 55", ex_b, ex_store_data); end
    checks++; if (ex_memwrite !== 1'b1) begin failures++; $display("FAIL wt_memwrite got=%0h exp=1", ex_memwrite); end
    id_valid = 1; id_rs2 = 5'd2; id_rd2 = 32'h77; id_alusrc = 1; id_imm = 32'h123;
    tick();
    checks++; if (ex_b !== 32'h123 || ex_store_data !== 32'h77) begin failures++; $display("FAIL alusrc_imm got b=%0h sd=%0h exp 123/77", ex_b, ex_store_data); end
    clear_inputs();
    id_valid = 0; id_regwrite = 1; id_memread = 1; id_memwrite = 1; id_rd = 5'd3;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_memread !== 1'b0 || ex_memwrite !== 1'b0) begin failures++; $display("FAIL invalid_ctrl got v=%0h rw=%0h mr=%0h mw=%0h exp 0", ex_valid, ex_regwrite, ex_memread, ex_memwrite); end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_priority();
    test_load_use();
    test_hold_refresh();
    test_flush();
    test_write_through();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
